// File: rtl/uart_mem_bridge_if.sv
// rtl/uart_mem_bridge_if.sv - UART byte streams plus single-beat memory port for the debug bridge
// master is the bridge side; slave is the UART buffers and memory side.
interface uart_mem_bridge_if #(
  parameter int addr_width_p = 32,
  parameter int data_width_p = 64
);
  logic                    rx_v_i;
  logic [7:0]              rx_i;
  logic                    rx_yumi_o;
  logic                    tx_v_o;
  logic [7:0]              tx_o;
  logic                    tx_ready_and_i;
  logic                    mem_v_o;
  logic                    mem_w_o;
  logic [addr_width_p-1:0] mem_addr_o;
  logic [data_width_p-1:0] mem_data_o;
  logic                    mem_ready_and_i;
  logic                    mem_resp_v_i;
  logic [data_width_p-1:0] mem_resp_data_i;
  logic                    mem_resp_yumi_o;
  logic                    error_o;
  logic                    busy_o;

  modport master (
    input  rx_v_i, rx_i, tx_ready_and_i, mem_ready_and_i, mem_resp_v_i, mem_resp_data_i,
    output rx_yumi_o, tx_v_o, tx_o, mem_v_o, mem_w_o, mem_addr_o, mem_data_o,
           mem_resp_yumi_o, error_o, busy_o
  );

  modport slave (
    output rx_v_i, rx_i, tx_ready_and_i, mem_ready_and_i, mem_resp_v_i, mem_resp_data_i,
    input  rx_yumi_o, tx_v_o, tx_o, mem_v_o, mem_w_o, mem_addr_o, mem_data_o,
           mem_resp_yumi_o, error_o, busy_o
  );
endinterface

// File: rtl/uart_mem_bridge.sv
// rtl/uart_mem_bridge.sv - serial command decoder issuing single-beat memory reads and writes
// Frames: 0x01 addr data (write, acked with 0x81) or 0x02 addr (read, data returned LSB first).
module uart_mem_bridge #(
  parameter int addr_width_p = 32,
  parameter int data_width_p = 64
) (
  input logic               clk_i,
  input logic               reset_i,
  uart_mem_bridge_if.master bus
);
  localparam int addr_bytes_lp = addr_width_p / 8;
  localparam int data_bytes_lp = data_width_p / 8;
  localparam int max_bytes_lp  = (addr_bytes_lp > data_bytes_lp) ? addr_bytes_lp : data_bytes_lp;
  localparam int cnt_width_lp  = $clog2(max_bytes_lp + 1);
  localparam logic [cnt_width_lp-1:0] addr_last_lp = cnt_width_lp'(addr_bytes_lp - 1);
  localparam logic [cnt_width_lp-1:0] data_last_lp = cnt_width_lp'(data_bytes_lp - 1);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, REQ, RESP, SEND, ACK, ERR} state_e;

  state_e                  state_q, state_d;
  logic [cnt_width_lp-1:0] cnt_q, cnt_d;
  logic                    write_q, write_d;
  logic                    error_q, error_d;
  logic [addr_width_p-1:0] addr_q, addr_d;
  logic [data_width_p-1:0] data_q, data_d;

  logic rx_yumi, tx_v, tx_fire;

  assign rx_yumi = bus.rx_v_i & ((state_q == IDLE) | (state_q == ADDR) | (state_q == DATA));
  assign tx_v    = (state_q == SEND) | (state_q == ACK) | (state_q == ERR);
  assign tx_fire = tx_v & bus.tx_ready_and_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    error_d = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      IDLE: if (bus.rx_v_i) begin
        cnt_d = '0;
        if ((bus.rx_i == 8'h01) || (bus.rx_i == 8'h02)) begin
          write_d = (bus.rx_i == 8'h01);
          state_d = ADDR;
        end else begin
          error_d = 1'b1;
          state_d = ERR;
        end
      end
      // Bytes arrive LSB first, so shifting in from the top leaves byte 0 at the bottom.
      ADDR: if (bus.rx_v_i) begin
        addr_d = addr_width_p'({bus.rx_i, addr_q} >> 8);
        if (cnt_q == addr_last_lp) begin
          cnt_d   = '0;
          state_d = write_q ? DATA : REQ;
        end else begin
          cnt_d = cnt_q + cnt_width_lp'(1);
        end
      end
      DATA: if (bus.rx_v_i) begin
        data_d = data_width_p'({bus.rx_i, data_q} >> 8);
        if (cnt_q == data_last_lp) begin
          cnt_d   = '0;
          state_d = REQ;
        end else begin
          cnt_d = cnt_q + cnt_width_lp'(1);
        end
      end
      REQ: if (bus.mem_ready_and_i) state_d = write_q ? ACK : RESP;
      RESP: if (bus.mem_resp_v_i) begin
        data_d  = bus.mem_resp_data_i;
        cnt_d   = '0;
        state_d = SEND;
      end
      SEND: if (bus.tx_ready_and_i) begin
        data_d = data_q >> 8;
        if (cnt_q == data_last_lp) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + cnt_width_lp'(1);
        end
      end
      ACK:     if (bus.tx_ready_and_i) state_d = IDLE;
      ERR:     if (bus.tx_ready_and_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      error_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      error_q <= error_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    bus.tx_o = 8'h00;
    case (state_q)
      SEND:    bus.tx_o = data_q[7:0];
      ACK:     bus.tx_o = 8'h81;
      ERR:     bus.tx_o = 8'hFF;
      default: bus.tx_o = 8'h00;
    endcase
  end

  assign bus.rx_yumi_o       = rx_yumi;
  assign bus.tx_v_o          = tx_v;
  assign bus.mem_v_o         = (state_q == REQ);
  assign bus.mem_w_o         = write_q;
  assign bus.mem_addr_o      = addr_q;
  assign bus.mem_data_o      = data_q;
  assign bus.mem_resp_yumi_o = (state_q == RESP) & bus.mem_resp_v_i;
  assign bus.error_o         = error_q;
  assign bus.busy_o          = (state_q != IDLE);

  logic unused_tx_fire;
  assign unused_tx_fire = tx_fire;
endmodule

// File: tb/tb_uart_mem_bridge.sv
// tb/tb_uart_mem_bridge.sv - directed frame tests with RX/TX/memory agents and a byte log
module tb_uart_mem_bridge;
  logic clk = 1'b0;
  logic reset_i = 1'b1;
  always #5 clk = ~clk;

  uart_mem_bridge_if #(.addr_width_p(32), .data_width_p(64)) bus ();
  uart_mem_bridge #(.addr_width_p(32), .data_width_p(64)) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .bus     (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [7:0]  rx_fifo[$];
  logic [7:0]  tx_log[$];
  logic [7:0]  exp_tx[$];
  logic [63:0] resp_fifo[$];
  logic        req_w[$];
  logic [31:0] req_addr[$];
  logic [63:0] req_data[$];

  logic rst_req = 1'b1;
  logic tx_toggle = 1'b0;
  int   mem_stall = 0;
  int   reads_acc = 0;
  int   resps_done = 0;
  int   cyc = 0;
  int   stab_err = 0;
  int   win_viol = 0;
  int   err_cycles = 0;
  logic win = 1'b0;
  int   first_yumi, first_memv, accept_cyc, first_tx, last_tx;
  logic busy_after;

  logic        prev_mem_stall = 1'b0;
  logic [31:0] prev_addr;
  logic [63:0] prev_data;
  logic        prev_w;
  logic        prev_tx_stall = 1'b0;
  logic [7:0]  prev_tx;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic mark();
    first_yumi = -1; first_memv = -1; accept_cyc = -1;
    first_tx = -1; last_tx = -10; busy_after = 1'bx;
    err_cycles = 0; stab_err = 0; win_viol = 0;
  endtask

  task automatic step();
    @(negedge clk);
    reset_i             = rst_req;
    bus.rx_v_i          = (rx_fifo.size() > 0);
    bus.rx_i            = (rx_fifo.size() > 0) ? rx_fifo[0] : 8'h00;
    bus.tx_ready_and_i  = tx_toggle ? cyc[0] : 1'b1;
    bus.mem_ready_and_i = (mem_stall == 0);
    bus.mem_resp_v_i    = (resp_fifo.size() > 0) && (reads_acc > resps_done);
    bus.mem_resp_data_i = (resp_fifo.size() > 0) ? resp_fifo[0] : 64'h0;
    #1;
    if (bus.rx_v_i && bus.rx_yumi_o) begin
      void'(rx_fifo.pop_front());
      if (first_yumi < 0) first_yumi = cyc;
      if (win) win_viol++;
    end
    if (bus.mem_v_o) begin
      if (first_memv < 0) first_memv = cyc;
      if (prev_mem_stall && (bus.mem_addr_o !== prev_addr || bus.mem_data_o !== prev_data ||
                             bus.mem_w_o !== prev_w)) stab_err++;
      if (bus.mem_w_o) win = 1'b1;
      if (bus.mem_ready_and_i) begin
        req_w.push_back(bus.mem_w_o);
        req_addr.push_back(bus.mem_addr_o);
        req_data.push_back(bus.mem_data_o);
        accept_cyc = cyc;
        if (!bus.mem_w_o) reads_acc++;
      end else if (mem_stall > 0) begin
        mem_stall--;
      end
    end
    prev_mem_stall = bus.mem_v_o && !bus.mem_ready_and_i;
    prev_addr = bus.mem_addr_o;
    prev_data = bus.mem_data_o;
    prev_w    = bus.mem_w_o;
    if (cyc == last_tx + 1) busy_after = bus.busy_o;
    if (bus.tx_v_o) begin
      if (prev_tx_stall && bus.tx_o !== prev_tx) stab_err++;
      if (bus.tx_ready_and_i) begin
        tx_log.push_back(bus.tx_o);
        if (first_tx < 0) first_tx = cyc;
        last_tx = cyc;
        win = 1'b0;
      end
    end
    prev_tx_stall = bus.tx_v_o && !bus.tx_ready_and_i;
    prev_tx = bus.tx_o;
    if (bus.mem_resp_yumi_o) begin
      void'(resp_fifo.pop_front());
      resps_done++;
    end
    if (bus.error_o) err_cycles++;
    cyc++;
  endtask

  task automatic drain(input string tag, input int budget);
    int quiet = 0;
    int n = 0;
    while (quiet < 3 && n < budget) begin
      step();
      n++;
      if (rx_fifo.size() == 0 && !bus.busy_o) quiet++;
      else quiet = 0;
    end
    if (quiet < 3) chk({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic push_write(input logic [31:0] a, input logic [63:0] d);
    rx_fifo.push_back(8'h01);
    for (int i = 0; i < 4; i++) rx_fifo.push_back(a[i*8 +: 8]);
    for (int i = 0; i < 8; i++) rx_fifo.push_back(d[i*8 +: 8]);
  endtask

  task automatic push_read(input logic [31:0] a);
    rx_fifo.push_back(8'h02);
    for (int i = 0; i < 4; i++) rx_fifo.push_back(a[i*8 +: 8]);
  endtask

  task automatic exp_read_bytes(input logic [63:0] d);
    for (int i = 0; i < 8; i++) exp_tx.push_back(d[i*8 +: 8]);
  endtask

  task automatic check_tx(input string tag);
    chk({tag, "_tx_count"}, 64'(tx_log.size()), 64'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size() && i < tx_log.size(); i++)
      chk($sformatf("%s_tx%0d", tag, i), 64'(tx_log[i]), 64'(exp_tx[i]));
    tx_log.delete();
    exp_tx.delete();
  endtask

  task automatic check_req(input string tag, input int idx, input logic w,
                           input logic [31:0] a, input logic [63:0] d, input logic chk_data);
    if (req_w.size() <= idx) begin
      chk({tag, "_req_missing"}, 64'(req_w.size()), 64'(idx + 1));
    end else begin
      chk({tag, "_w"}, 64'(req_w[idx]), 64'(w));
      chk({tag, "_addr"}, 64'(req_addr[idx]), 64'(a));
      if (chk_data) chk({tag, "_data"}, req_data[idx], d);
    end
  endtask

  task automatic clear_reqs();
    req_w.delete(); req_addr.delete(); req_data.delete();
  endtask

  initial begin
    bus.rx_v_i = 1'b0; bus.rx_i = 8'h00; bus.tx_ready_and_i = 1'b1;
    bus.mem_ready_and_i = 1'b1; bus.mem_resp_v_i = 1'b0; bus.mem_resp_data_i = '0;
    mark();
    step();
    step();
    chk("rst_rx_yumi", 64'(bus.rx_yumi_o), 64'd0);
    chk("rst_tx_v", 64'(bus.tx_v_o), 64'd0);
    chk("rst_tx", 64'(bus.tx_o), 64'd0);
    chk("rst_mem_v", 64'(bus.mem_v_o), 64'd0);
    chk("rst_mem_w", 64'(bus.mem_w_o), 64'd0);
    chk("rst_mem_addr", 64'(bus.mem_addr_o), 64'd0);
    chk("rst_mem_data", bus.mem_data_o, 64'd0);
    chk("rst_resp_yumi", 64'(bus.mem_resp_yumi_o), 64'd0);
    chk("rst_error", 64'(bus.error_o), 64'd0);
    chk("rst_busy", 64'(bus.busy_o), 64'd0);
    rst_req = 1'b0;
    step();

    // Write, memory always ready
    mark();
    push_write(32'h8000_0010, 64'h8877_6655_4433_2211);
    drain("wr", 200);
    check_req("wr", 0, 1'b1, 32'h8000_0010, 64'h8877_6655_4433_2211, 1'b1);
    chk("wr_req_count", 64'(req_w.size()), 64'd1);
    chk("wr_frame_latency", 64'(first_memv - first_yumi), 64'd13);
    chk("wr_ack_latency", 64'(first_tx - accept_cyc), 64'd1);
    exp_tx.push_back(8'h81);
    check_tx("wr");
    clear_reqs();

    // Read
    mark();
    resp_fifo.push_back(64'h0123_4567_89AB_CDEF);
    push_read(32'h8000_0008);
    drain("rd", 200);
    check_req("rd", 0, 1'b0, 32'h8000_0008, 64'h0, 1'b0);
    chk("rd_send_latency", 64'(first_tx - accept_cyc), 64'd2);
    chk("rd_tx_consecutive", 64'(last_tx - first_tx), 64'd7);
    chk("rd_busy_after", 64'(busy_after), 64'd0);
    exp_read_bytes(64'h0123_4567_89AB_CDEF);
    check_tx("rd");
    clear_reqs();

    // Bad opcode followed by a valid read
    mark();
    resp_fifo.push_back(64'h1122_3344_5566_7788);
    rx_fifo.push_back(8'h5A);
    push_read(32'h8000_0008);
    drain("bad", 200);
    chk("bad_error_cycles", 64'(err_cycles), 64'd1);
    chk("bad_req_count", 64'(req_w.size()), 64'd1);
    check_req("bad", 0, 1'b0, 32'h8000_0008, 64'h0, 1'b0);
    exp_tx.push_back(8'hFF);
    exp_read_bytes(64'h1122_3344_5566_7788);
    check_tx("bad");
    clear_reqs();

    // Backpressure on memory and TX
    mark();
    tx_toggle = 1'b1;
    mem_stall = 10;
    push_write(32'h1234_5678, 64'hDEAD_BEEF_CAFE_F00D);
    drain("bp_wr", 300);
    mem_stall = 10;
    resp_fifo.push_back(64'hA5A5_0102_0304_5A5A);
    push_read(32'h0000_00F0);
    drain("bp_rd", 300);
    tx_toggle = 1'b0;
    chk("bp_stable", 64'(stab_err), 64'd0);
    check_req("bp_wr", 0, 1'b1, 32'h1234_5678, 64'hDEAD_BEEF_CAFE_F00D, 1'b1);
    check_req("bp_rd", 1, 1'b0, 32'h0000_00F0, 64'h0, 1'b0);
    exp_tx.push_back(8'h81);
    exp_read_bytes(64'hA5A5_0102_0304_5A5A);
    check_tx("bp");
    clear_reqs();

    // Write immediately followed by a read in the RX buffer
    mark();
    resp_fifo.push_back(64'hFEDC_BA98_7654_3210);
    push_write(32'h0000_1000, 64'h0F0E_0D0C_0B0A_0908);
    push_read(32'h0000_2000);
    drain("pipe", 300);
    chk("pipe_rx_hold", 64'(win_viol), 64'd0);
    chk("pipe_req_count", 64'(req_w.size()), 64'd2);
    check_req("pipe_wr", 0, 1'b1, 32'h0000_1000, 64'h0F0E_0D0C_0B0A_0908, 1'b1);
    check_req("pipe_rd", 1, 1'b0, 32'h0000_2000, 64'h0, 1'b0);
    exp_tx.push_back(8'h81);
    exp_read_bytes(64'hFEDC_BA98_7654_3210);
    check_tx("pipe");
    clear_reqs();

    // Reset after opcode and three address bytes
    mark();
    rx_fifo.push_back(8'h02);
    rx_fifo.push_back(8'hAA);
    rx_fifo.push_back(8'hBB);
    rx_fifo.push_back(8'hCC);
    for (int i = 0; i < 4; i++) step();
    chk("mid_busy_before_rst", 64'(bus.busy_o), 64'd1);
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("mid_no_req", 64'(req_w.size()), 64'd0);
    chk("mid_no_tx", 64'(tx_log.size()), 64'd0);
    chk("mid_idle", 64'(bus.busy_o), 64'd0);
    resp_fifo.push_back(64'h0011_2233_4455_6677);
    push_read(32'h8000_0040);
    drain("mid", 200);
    chk("mid_req_count", 64'(req_w.size()), 64'd1);
    check_req("mid_rd", 0, 1'b0, 32'h8000_0040, 64'h0, 1'b0);
    exp_read_bytes(64'h0011_2233_4455_6677);
    check_tx("mid");
    clear_reqs();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/uart_mem_bridge.md
# uart_mem_bridge

Byte-stream command decoder that sits directly downstream of the buffered UART receiver and upstream of the UART transmit buffer. It consumes received bytes, assembles write and read command frames, issues single-beat memory requests, and returns read data or a write acknowledgement as bytes to the transmitter. It is the host-debug path into on-chip memory over the serial link.

## Interface
Parameters:
- addr_width_p, 32, memory address width; must be a multiple of 8 and at least 8
- data_width_p, 64, memory data width; must be a multiple of 8 and at least 8
- Derived: addr_bytes = addr_width_p/8, data_bytes = data_width_p/8

Ports:
- clk_i  in  1  clock; all logic is on the rising edge
- reset_i  in  1  synchronous, active-high reset
- rx_v_i  in  1  received byte valid, from the UART RX buffer
- rx_i  in  8  received byte
- rx_yumi_o  out  1  byte consumed this cycle (valid-then-yumi)
- tx_v_o  out  1  transmit byte valid, to the UART TX buffer
- tx_o  out  8  transmit byte
- tx_ready_and_i  in  1  TX buffer accepts; transfer occurs when tx_v_o & tx_ready_and_i
- mem_v_o  out  1  memory request valid
- mem_w_o  out  1  1 = write, 0 = read
- mem_addr_o  out  addr_width_p  request address
- mem_data_o  out  data_width_p  write data
- mem_ready_and_i  in  1  request accepted when mem_v_o & mem_ready_and_i
- mem_resp_v_i  in  1  read response valid
- mem_resp_data_i  in  data_width_p  read response data
- mem_resp_yumi_o  out  1  read response consumed
- error_o  out  1  one-cycle pulse on an unknown opcode
- busy_o  out  1  high in every state except IDLE

## Operation
- Frame formats: write = 0x01, addr_bytes address bytes, data_bytes data bytes. Read = 0x02, addr_bytes address bytes. Multi-byte fields are sent LSB first.
- States: IDLE, ADDR, DATA, REQ, RESP, SEND, ACK, ERR.
- IDLE: consume one byte.
  - 0x01 or 0x02 → ADDR; latch the opcode and clear the byte counter.
  - Any other value → ERR.
- ADDR: consume a byte into address byte [cnt]. On cnt == addr_bytes-1: write → DATA, read → REQ. Clear the counter.
- DATA: consume a byte into data byte [cnt]. On cnt == data_bytes-1 → REQ.
- REQ: mem_v_o = 1. Address, data and mem_w_o are held stable until accepted. On accept: write → ACK, read → RESP.
- RESP: mem_resp_yumi_o = mem_resp_v_i. On a response, latch the data into the shift register → SEND, with the counter cleared.
- SEND: tx_v_o = 1 and tx_o = data byte [cnt]. On each transfer, increment cnt. Transfer of byte data_bytes-1 → IDLE.
- ACK: tx_v_o = 1, tx_o = 0x81. On transfer → IDLE.
- ERR: error_o = 1 for this single cycle, and tx_v_o = 1 with tx_o = 0xFF. error_o is asserted only on entry cycle. Hold tx_v_o until the transfer, then → IDLE.
- rx_yumi_o = rx_v_i only in IDLE, ADDR and DATA. It is 0 in all other states, so bytes arriving during REQ through ERR stay in the RX buffer.
- The byte counter is $clog2(max(addr_bytes, data_bytes)+1) bits wide. It saturates by state transition and never wraps.
- The address and data registers are not cleared between frames. Every byte is overwritten before use.
- A mem_resp_v_i outside RESP is ignored and not consumed.

## Timing
- Reset:
  - State = IDLE and counter = 0.
  - All outputs are 0: rx_yumi_o, tx_v_o, tx_o, mem_v_o, mem_w_o, mem_addr_o, mem_data_o, mem_resp_yumi_o, error_o, busy_o.
  - A reset asserted mid-frame aborts the frame with no memory request or TX byte.
  - A reset asserted mid-REQ drops mem_v_o the next cycle.
- rx_yumi_o, mem_resp_yumi_o and tx_v_o are combinational from state and inputs. Every other output is registered or decoded from state.
- One byte is consumed per cycle at most. A back-to-back write frame with no stalls takes 1+addr_bytes+data_bytes cycles to reach REQ.
- REQ is entered the cycle after the last frame byte. A zero-stall write emits ACK the cycle after mem accept.
- Read: SEND is entered the cycle after the response. With tx_ready_and_i held at 1, data_bytes TX transfers occur on consecutive cycles.
- Output values are held while the handshake partner stalls: tx_o while tx_ready_and_i = 0, mem_* while mem_ready_and_i = 0.

## Test plan
- Write: bytes 01, 10 00 00 80, 11 22 33 44 55 66 77 88 with the memory always ready → one request: mem_w_o = 1, addr 0x80000010, data 0x8877665544332211. TX emits 0x81.
- Read: bytes 02, 08 00 00 80, response data 0x0123456789ABCDEF → mem_w_o = 0, addr 0x80000008. TX emits EF CD AB 89 67 45 23 01, then busy_o = 0.
- Bad opcode: byte 0x5A → error_o pulses for exactly 1 cycle and TX emits 0xFF. The next byte 0x02 starts a valid read.
- Backpressure: mem_ready_and_i low for 10 cycles and tx_ready_and_i toggling → mem_addr_o, mem_data_o and tx_o are stable while stalled. No bytes are duplicated or lost.
- Pipelined frames: a write frame is immediately followed by a read frame in the RX buffer → rx_yumi_o stays 0 from REQ until the ACK transfer completes. Both frames complete correctly.
- Reset mid-frame: reset after 3 address bytes, then a full valid read → no request from the aborted frame. The read completes correctly.
